// File: rtl/cfu_bus_arbiter.sv
// cfu_bus_arbiter: shares one CFU between two command sources over the CFU cmd/rsp bus.
// Latency: grant in IDLE, CFU issue next cycle, rsp_valid one cycle after the CFU rsp fire.
// Backpressure: one command in flight; RESP holds until the owner takes the response.
//
// Ports:
//   clk, rst                    - single clock, synchronous active-high reset
//   io_req{0,1}_cmd_*           - requester command channels (ready is a grant pulse in IDLE)
//   io_req{0,1}_rsp_*           - requester response channels (payload from shared rsp regs)
//   io_cfu_cmd_*, io_cfu_rsp_*  - downstream CFU command/response channels
// Config macro: CFU_ARB_ROUND_ROBIN_EN selects round-robin on contention;
//   when undefined, requester 0 has fixed priority.

module cfu_bus_arbiter #(
  parameter int DATA_W = 32,
  parameter int FID_W  = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              io_req0_cmd_valid,
  output logic              io_req0_cmd_ready,
  input  logic [FID_W-1:0]  io_req0_cmd_payload_function_id,
  input  logic [DATA_W-1:0] io_req0_cmd_payload_inputs_0,
  input  logic [DATA_W-1:0] io_req0_cmd_payload_inputs_1,
  output logic              io_req0_rsp_valid,
  input  logic              io_req0_rsp_ready,
  output logic              io_req0_rsp_payload_response_ok,
  output logic [DATA_W-1:0] io_req0_rsp_payload_outputs_0,

  input  logic              io_req1_cmd_valid,
  output logic              io_req1_cmd_ready,
  input  logic [FID_W-1:0]  io_req1_cmd_payload_function_id,
  input  logic [DATA_W-1:0] io_req1_cmd_payload_inputs_0,
  input  logic [DATA_W-1:0] io_req1_cmd_payload_inputs_1,
  output logic              io_req1_rsp_valid,
  input  logic              io_req1_rsp_ready,
  output logic              io_req1_rsp_payload_response_ok,
  output logic [DATA_W-1:0] io_req1_rsp_payload_outputs_0,

  output logic              io_cfu_cmd_valid,
  input  logic              io_cfu_cmd_ready,
  output logic [FID_W-1:0]  io_cfu_cmd_payload_function_id,
  output logic [DATA_W-1:0] io_cfu_cmd_payload_inputs_0,
  output logic [DATA_W-1:0] io_cfu_cmd_payload_inputs_1,
  input  logic              io_cfu_rsp_valid,
  output logic              io_cfu_rsp_ready,
  input  logic              io_cfu_rsp_payload_response_ok,
  input  logic [DATA_W-1:0] io_cfu_rsp_payload_outputs_0
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

`ifdef CFU_ARB_ROUND_ROBIN_EN
  localparam logic ROUND_ROBIN = 1'b1;
`else
  localparam logic ROUND_ROBIN = 1'b0;
`endif

  state_t              state;
  state_t              state_nxt;
  logic                owner;
  logic                last_grant;
  logic [FID_W-1:0]    cmd_fid;
  logic [DATA_W-1:0]   cmd_in0;
  logic [DATA_W-1:0]   cmd_in1;
  logic                rsp_ok;
  logic [DATA_W-1:0]   rsp_out0;

  logic                any_vld;
  logic                winner;
  logic                grant;
  logic                latch_rsp;

  assign any_vld = io_req0_cmd_valid | io_req1_cmd_valid;

  // On contention round-robin prefers the side not granted last; fixed
  // priority collapses this term to requester 0. A lone requester always wins.
  assign winner = (io_req0_cmd_valid & io_req1_cmd_valid) ? (ROUND_ROBIN & ~last_grant)
                                                          : ~io_req0_cmd_valid;

  assign io_req0_cmd_ready = grant & ~winner;
  assign io_req1_cmd_ready = grant &  winner;

  assign io_cfu_cmd_payload_function_id = cmd_fid;
  assign io_cfu_cmd_payload_inputs_0    = cmd_in0;
  assign io_cfu_cmd_payload_inputs_1    = cmd_in1;

  // Both requester ports see the response registers; rsp_valid alone selects the owner.
  assign io_req0_rsp_payload_response_ok = rsp_ok;
  assign io_req0_rsp_payload_outputs_0   = rsp_out0;
  assign io_req1_rsp_payload_response_ok = rsp_ok;
  assign io_req1_rsp_payload_outputs_0   = rsp_out0;

  always_comb begin
    state_nxt         = state;
    grant             = 1'b0;
    latch_rsp         = 1'b0;
    io_cfu_cmd_valid  = 1'b0;
    io_cfu_rsp_ready  = 1'b0;
    io_req0_rsp_valid = 1'b0;
    io_req1_rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (any_vld) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        io_cfu_cmd_valid = 1'b1;
        // rsp_ready must already be high here: a combinational CFU ties its
        // cmd_ready to our rsp_ready and answers in the same cycle.
        io_cfu_rsp_ready = 1'b1;
        if (io_cfu_cmd_ready) begin
          if (io_cfu_rsp_valid) begin
            latch_rsp = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        io_cfu_rsp_ready = 1'b1;
        if (io_cfu_rsp_valid) begin
          latch_rsp = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        io_req0_rsp_valid = ~owner;
        io_req1_rsp_valid =  owner;
        if (owner ? io_req1_rsp_ready : io_req0_rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cmd_fid    <= '0;
      cmd_in0    <= '0;
      cmd_in1    <= '0;
      rsp_ok     <= 1'b0;
      rsp_out0   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner      <= winner;
        last_grant <= winner;
        cmd_fid    <= winner ? io_req1_cmd_payload_function_id : io_req0_cmd_payload_function_id;
        cmd_in0    <= winner ? io_req1_cmd_payload_inputs_0    : io_req0_cmd_payload_inputs_0;
        cmd_in1    <= winner ? io_req1_cmd_payload_inputs_1    : io_req0_cmd_payload_inputs_1;
      end
      if (latch_rsp) begin
        rsp_ok   <= io_cfu_rsp_payload_response_ok;
        rsp_out0 <= io_cfu_rsp_payload_outputs_0;
      end
    end
  end

endmodule

// File: tb/tb_cfu_bus_arbiter.sv
// tb_cfu_bus_arbiter: randomized bench for cfu_bus_arbiter with a transaction-level model.
// CFU is either combinational or a multi-cycle model (cmd_ready after 3, rsp after 5 cycles).
// Requesters drive from per-side command queues; responses checked against the model.

module tb_cfu_bus_arbiter;

  typedef struct packed {
    logic [2:0]  fid;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

`ifdef CFU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  cmd_v;
  logic [2:0]  cmd_f [2];
  logic [31:0] cmd_a [2];
  logic [31:0] cmd_b [2];
  logic [1:0]  rsp_r;

  logic        c0_rdy, c1_rdy, r0_vld, r1_vld, r0_ok, r1_ok;
  logic [31:0] r0_out, r1_out;
  logic        cfu_cmd_vld, cfu_cmd_rdy, cfu_rsp_vld, cfu_rsp_rdy, cfu_ok;
  logic [2:0]  cfu_fid;
  logic [31:0] cfu_a, cfu_b, cfu_out;

  cfu_bus_arbiter #(.DATA_W(32), .FID_W(3)) dut (
    .clk(clk), .rst(rst),
    .io_req0_cmd_valid(cmd_v[0]), .io_req0_cmd_ready(c0_rdy),
    .io_req0_cmd_payload_function_id(cmd_f[0]),
    .io_req0_cmd_payload_inputs_0(cmd_a[0]), .io_req0_cmd_payload_inputs_1(cmd_b[0]),
    .io_req0_rsp_valid(r0_vld), .io_req0_rsp_ready(rsp_r[0]),
    .io_req0_rsp_payload_response_ok(r0_ok), .io_req0_rsp_payload_outputs_0(r0_out),
    .io_req1_cmd_valid(cmd_v[1]), .io_req1_cmd_ready(c1_rdy),
    .io_req1_cmd_payload_function_id(cmd_f[1]),
    .io_req1_cmd_payload_inputs_0(cmd_a[1]), .io_req1_cmd_payload_inputs_1(cmd_b[1]),
    .io_req1_rsp_valid(r1_vld), .io_req1_rsp_ready(rsp_r[1]),
    .io_req1_rsp_payload_response_ok(r1_ok), .io_req1_rsp_payload_outputs_0(r1_out),
    .io_cfu_cmd_valid(cfu_cmd_vld), .io_cfu_cmd_ready(cfu_cmd_rdy),
    .io_cfu_cmd_payload_function_id(cfu_fid),
    .io_cfu_cmd_payload_inputs_0(cfu_a), .io_cfu_cmd_payload_inputs_1(cfu_b),
    .io_cfu_rsp_valid(cfu_rsp_vld), .io_cfu_rsp_ready(cfu_rsp_rdy),
    .io_cfu_rsp_payload_response_ok(cfu_ok), .io_cfu_rsp_payload_outputs_0(cfu_out)
  );

  // ---------------- CFU models ----------------
  logic        mode;      // 0: combinational CFU, 1: multi-cycle CFU
  int          mc_cw, mc_rc;
  logic        mc_busy, mc_ok;
  logic [31:0] mc_res;
  logic        mc_cmd_rdy, mc_rsp_v;

  function automatic logic [31:0] cfu_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[0] ? b : a;
  endfunction

  assign mc_cmd_rdy  = mode && cfu_cmd_vld && !mc_busy && (mc_cw == 3);
  assign mc_rsp_v    = mode && mc_busy && (mc_rc == 4);
  assign cfu_cmd_rdy = mode ? mc_cmd_rdy : cfu_rsp_rdy;
  assign cfu_rsp_vld = mode ? mc_rsp_v : cfu_cmd_vld;
  assign cfu_out     = mode ? mc_res : cfu_fn(cfu_fid, cfu_a, cfu_b);
  assign cfu_ok      = mode ? mc_ok : ~cfu_fid[2];

  always @(posedge clk) begin
    if (rst || !mode) begin
      mc_cw <= 0; mc_rc <= 0; mc_busy <= 1'b0; mc_res <= '0; mc_ok <= 1'b0;
    end else begin
      if (cfu_cmd_vld && !mc_cmd_rdy) mc_cw <= mc_cw + 1;
      else                            mc_cw <= 0;
      if (cfu_cmd_vld && mc_cmd_rdy) begin
        mc_busy <= 1'b1; mc_rc <= 0;
        mc_res  <= cfu_fn(cfu_fid, cfu_a, cfu_b);
        mc_ok   <= ~cfu_fid[2];
      end else if (mc_rsp_v && cfu_rsp_rdy) begin
        mc_busy <= 1'b0;
      end else if (mc_busy && !mc_rsp_v) begin
        mc_rc <= mc_rc + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- requester drivers ----------------
  cmd_t q0[$];
  cmd_t q1[$];
  int   rdy_mode [2];   // 0 random, 1 high, 2 low
  logic gaps, hold;
  logic [1:0] gnt_fire;

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.fid = 3'($urandom_range(0, 7));
    c.a   = $urandom;
    c.b   = $urandom;
    return c;
  endfunction

  task automatic drive();
    cmd_t h;
    logic have;
    for (int n = 0; n < 2; n++) begin
      have = (n == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) h = (n == 0) ? q0[0] : q1[0];
      else      h = rnd_cmd();
      cmd_v[n] = have && !hold && (!gaps || $urandom_range(0, 3) != 0);
      cmd_f[n] = h.fid;
      cmd_a[n] = h.a;
      cmd_b[n] = h.b;
      if (rdy_mode[n] == 0)      rsp_r[n] = ($urandom_range(0, 1) == 1);
      else if (rdy_mode[n] == 1) rsp_r[n] = 1'b1;
      else                       rsp_r[n] = 1'b0;
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic        busy, owner, pend_cmd, pend_rsp, have_rsp, prev_grant, first_rsp;
  cmd_t        exp_cmd;
  logic [31:0] exp_out;
  logic        exp_ok;
  int          cyc = 0, grant_cyc, cfu_fire_cyc;
  int          gnt_log[$];
  int          dlv_own[$];
  logic [31:0] dlv_out[$];
  logic        last_ok;
  int          ndone [2];

  task automatic model_reset();
    busy = 0; owner = 0; pend_cmd = 0; pend_rsp = 0; have_rsp = 0;
    prev_grant = 1; first_rsp = 0;
  endtask

  // One clock: check at the falling edge, advance queues and drivers after the rising edge.
  task automatic step();
    logic b, h, pc, pr, w, cmdf, rspf, rok;
    logic [31:0] ro;
    @(negedge clk);
    cyc++;
    gnt_fire = 2'b00;
    b = busy; h = have_rsp; pc = pend_cmd; pr = pend_rsp;

    chk("rsp_vld0", 32'(r0_vld), 32'(h && !owner));
    chk("rsp_vld1", 32'(r1_vld), 32'(h && owner));
    if (h) begin
      ro  = owner ? r1_out : r0_out;
      rok = owner ? r1_ok  : r0_ok;
      chk("rsp_out", ro, exp_out);
      chk("rsp_ok", 32'(rok), 32'(exp_ok));
      if (first_rsp) begin
        chk("rsp_lat_cfu", 32'(cyc), 32'(cfu_fire_cyc + 1));
        if (!mode) chk("rsp_lat_grant", 32'(cyc), 32'(grant_cyc + 2));
        first_rsp = 0;
      end
      if (rsp_r[owner]) begin
        busy = 0; have_rsp = 0;
        dlv_own.push_back(int'(owner)); dlv_out.push_back(ro);
        last_ok = rok;
        ndone[owner]++;
      end
    end

    chk("cfu_cmd_vld", 32'(cfu_cmd_vld), 32'(pc));
    chk("cfu_rsp_rdy", 32'(cfu_rsp_rdy), 32'(pc || pr));
    if (pc) begin
      chk("cfu_fid", 32'(cfu_fid), 32'(exp_cmd.fid));
      chk("cfu_in0", cfu_a, exp_cmd.a);
      chk("cfu_in1", cfu_b, exp_cmd.b);
    end
    cmdf = cfu_cmd_vld && cfu_cmd_rdy;
    rspf = cfu_rsp_vld && cfu_rsp_rdy;
    if (pc && cmdf) begin
      pend_cmd = 0;
      pend_rsp = !rspf;
      if (rspf) begin have_rsp = 1; first_rsp = 1; cfu_fire_cyc = cyc; end
    end else if (pr && rspf) begin
      pend_rsp = 0; have_rsp = 1; first_rsp = 1; cfu_fire_cyc = cyc;
    end

    if (!b && (cmd_v[0] || cmd_v[1])) begin
      if (cmd_v[0] && cmd_v[1]) w = RR ? !prev_grant : 1'b0;
      else                      w = cmd_v[1];
      chk("gnt0", 32'(c0_rdy), 32'(!w));
      chk("gnt1", 32'(c1_rdy), 32'(w));
      busy = 1; owner = w; prev_grant = w; pend_cmd = 1;
      exp_cmd   = w ? q1[0] : q0[0];
      exp_out   = cfu_fn(exp_cmd.fid, exp_cmd.a, exp_cmd.b);
      exp_ok    = ~exp_cmd.fid[2];
      grant_cyc = cyc;
      gnt_fire[w] = 1'b1;
      gnt_log.push_back(int'(w));
    end else begin
      chk("no_gnt0", 32'(c0_rdy), 32'(0));
      chk("no_gnt1", 32'(c1_rdy), 32'(0));
    end

    @(posedge clk); #1;
    if (gnt_fire[0]) void'(q0.pop_front());
    if (gnt_fire[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic run_until_idle(input int bound);
    int k;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy) && k < bound) begin
      step();
      k++;
    end
    chk("drain_timeout", 32'(k < bound), 32'(1));
  endtask

  task automatic check_all_zero();
    @(negedge clk);
    chk("zero_ctl", 32'({c0_rdy, c1_rdy, r0_vld, r1_vld, cfu_cmd_vld, cfu_rsp_rdy}), 32'(0));
    chk("zero_rsp_ok", 32'({r0_ok, r1_ok}), 32'(0));
    chk("zero_r0_out", r0_out, 32'(0));
    chk("zero_r1_out", r1_out, 32'(0));
    chk("zero_cfu_fid", 32'(cfu_fid), 32'(0));
    chk("zero_cfu_in0", cfu_a, 32'(0));
    chk("zero_cfu_in1", cfu_b, 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    hold = 1; drive();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    check_all_zero();
    hold = 0; drive();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, n0;
    cmd_t c;
    mode = 0; gaps = 0; hold = 1; rst = 1;
    rdy_mode[0] = 1; rdy_mode[1] = 1;
    ndone[0] = 0; ndone[1] = 0;
    model_reset();
    drive();
    do_reset();

    // Single req0 op on a combinational CFU.
    q0.push_back('{fid: 3'd1, a: 32'h11, b: 32'h22});
    drive();
    run_until_idle(20);
    chk("t1_out", dlv_out[$], 32'h22);
    chk("t1_ok", 32'(last_ok), 32'(1));
    chk("t1_req1_none", 32'(ndone[1]), 32'(0));

    // Continuous contention, 4 ops per side.
    do_reset();
    gnt_log.delete();
    for (int i = 0; i < 4; i++) begin q0.push_back(rnd_cmd()); q1.push_back(rnd_cmd()); end
    drive();
    run_until_idle(60);
    chk("t2_ngnt", 32'(gnt_log.size()), 32'(8));
    for (int i = 0; i < 8 && i < gnt_log.size(); i++)
      chk("t2_order", 32'(gnt_log[i]), RR ? 32'(i % 2) : 32'(i >= 4));

    // Multi-cycle CFU.
    mode = 1;
    c = rnd_cmd(); c.fid = 3'd1; c.b = 32'hDEADBEEF;
    q0.push_back(c);
    drive();
    run_until_idle(60);
    chk("t3_out", dlv_out[$], 32'hDEADBEEF);

    // Requester 1 holds off its response for 10 cycles while requester 0 waits.
    mode = 0;
    rdy_mode[1] = 2;
    q1.push_back('{fid: 3'd0, a: 32'hCAFE0001, b: 32'h0});
    drive();
    k = 0;
    while (!have_rsp && k < 20) begin step(); k++; end
    chk("t4_reach_resp", 32'(have_rsp), 32'(1));
    q0.push_back(rnd_cmd());
    drive();
    n0 = gnt_log.size();
    repeat (10) step();
    chk("t4_no_grant_held", 32'(gnt_log.size() - n0), 32'(0));
    chk("t4_still_owed", 32'(have_rsp), 32'(1));
    rdy_mode[1] = 1;
    drive();
    run_until_idle(40);
    chk("t4_dlv1_own", 32'(dlv_own[dlv_own.size() - 2]), 32'(1));
    chk("t4_dlv1_out", dlv_out[dlv_out.size() - 2], 32'hCAFE0001);
    chk("t4_dlv0_own", 32'(dlv_own[$]), 32'(0));

    // Reset while waiting on a multi-cycle CFU response.
    mode = 1;
    q0.push_back(rnd_cmd());
    drive();
    k = 0;
    while (!pend_rsp && k < 20) begin step(); k++; end
    chk("t5_reach_wait", 32'(pend_rsp), 32'(1));
    n0 = dlv_out.size();
    do_reset();
    chk("t5_dropped", 32'(dlv_out.size() - n0), 32'(0));
    c = rnd_cmd();
    q0.push_back(c);
    drive();
    run_until_idle(60);
    chk("t5_after_out", dlv_out[$], cfu_fn(c.fid, c.a, c.b));
    gnt_log.delete();
    q0.push_back(rnd_cmd()); q1.push_back(rnd_cmd());
    drive();
    run_until_idle(60);
    chk("t5_first_contended", 32'(gnt_log[0]), 32'(0));

    // Randomized traffic: random CFU type, valid gaps and response backpressure.
    gaps = 1;
    for (int s = 0; s < 8; s++) begin
      mode = ($urandom_range(0, 1) == 1);
      rdy_mode[0] = 0; rdy_mode[1] = 0;
      repeat ($urandom_range(3, 8)) q0.push_back(rnd_cmd());
      repeat ($urandom_range(3, 8)) q1.push_back(rnd_cmd());
      drive();
      run_until_idle(3000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
